// File: rtl/sneuron_pkg.sv
// Shared types and constants for the neuron accumulate/saturate stage.
// Optional ReLU clamp is enabled by defining SNEURON_RELU_EN.
package sneuron_pkg;

   localparam int DEF_NUM_TERMS = 8;
   localparam int DEF_SHIFT     = 4;
   localparam int PROD_W        = 17;
   localparam int OUT_W         = 14;
   localparam int ACC_W         = PROD_W + $clog2(DEF_NUM_TERMS) + 1;

   typedef enum logic [1:0] {IDLE = 2'd0, ACCUM = 2'd1, DONE = 2'd2} accum_state_t;

   typedef logic signed [PROD_W-1:0] prod_t;
   typedef logic signed [ACC_W-1:0]  acc_t;
   typedef logic signed [OUT_W-1:0]  out_t;

   localparam int   SAT_MAX   = (2 ** (OUT_W - 1)) - 1;
   localparam int   SAT_MIN   = -(2 ** (OUT_W - 1));
   localparam out_t OUT_MAX_V = OUT_W'(SAT_MAX);
   localparam out_t OUT_MIN_V = OUT_W'(SAT_MIN);

endpackage

// File: rtl/sneuron_sat.sv
// Combinational arithmetic shift + saturation to the output width.
// With SNEURON_RELU_EN defined, negative results clamp to zero without flagging.
module sneuron_sat
   import sneuron_pkg::*;
#(
   parameter int IN_W  = ACC_W,
   parameter int SHIFT = DEF_SHIFT
) (
   input  logic [IN_W-1:0]  acc,
   output logic [OUT_W-1:0] value,
   output logic             clip
);

   localparam logic signed [IN_W-1:0] SAT_HI = IN_W'(SAT_MAX);
   localparam logic signed [IN_W-1:0] SAT_LO = IN_W'(SAT_MIN);

   logic signed [IN_W-1:0] shifted_s;

   // Shift, clip to the signed output range, optionally rectify.
   always_comb begin
      shifted_s = $signed(acc) >>> SHIFT;
      value     = OUT_W'(shifted_s);
      clip      = 1'b0;
      if (shifted_s > SAT_HI) begin
         value = OUT_MAX_V;
         clip  = 1'b1;
      end else if (shifted_s < SAT_LO) begin
         value = OUT_MIN_V;
         clip  = 1'b1;
      end else begin
         value = OUT_W'(shifted_s);
         clip  = 1'b0;
      end
`ifdef SNEURON_RELU_EN
      // Rectification is not saturation, so it also clears a negative clip.
      if (value[OUT_W-1]) begin
         value = '0;
         clip  = 1'b0;
      end else begin
         value = value;
         clip  = clip;
      end
`endif
   end

endmodule

// File: rtl/sneuron_accum.sv
// Neuron accumulator: bias + NUM_TERMS signed products, scaled and saturated,
// delivered on a valid/ready handshake. ReLU option: SNEURON_RELU_EN.
module sneuron_accum
   import sneuron_pkg::*;
#(
   parameter int NUM_TERMS = DEF_NUM_TERMS,
   parameter int SHIFT     = DEF_SHIFT
) (
   input  logic              clk,
   input  logic              n_rst,
   input  logic              start,
   input  logic [OUT_W-1:0]  bias,
   input  logic              prod_valid,
   input  logic [PROD_W-1:0] prod_in,
   output logic              busy,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [OUT_W-1:0]  out_data,
   output logic              sat_flag
);

   localparam int ACC_L = PROD_W + $clog2(NUM_TERMS) + 1;
   localparam int CNT_W = (NUM_TERMS > 2) ? $clog2(NUM_TERMS) : 1;
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_TERMS - 1);

   accum_state_t            state_r, state_next_s;
   logic signed [ACC_L-1:0] acc_r, acc_sum_s, bias_ext_s;
   logic [CNT_W-1:0]        count_r;
   logic                    load_s, add_s, finish_s;
   logic [OUT_W-1:0]        sat_value_s;
   logic                    sat_clip_s;

   assign bias_ext_s = {{(ACC_L - OUT_W){bias[OUT_W-1]}}, bias};
   assign acc_sum_s  = acc_r + {{(ACC_L - PROD_W){prod_in[PROD_W-1]}}, prod_in};

   // The result is taken from the sum including the last product, so out_valid
   // rises on the edge right after it.
   sneuron_sat #(.IN_W(ACC_L), .SHIFT(SHIFT)) u_sat (
      .acc   (acc_sum_s),
      .value (sat_value_s),
      .clip  (sat_clip_s)
   );

   // State register.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_next_s;
      end
   end

   // Next-state and datapath control decode.
   always_comb begin
      state_next_s = state_r;
      load_s       = 1'b0;
      add_s        = 1'b0;
      finish_s     = 1'b0;
      case (state_r)
         IDLE: begin
            if (start) begin
               state_next_s = ACCUM;
               load_s       = 1'b1;
            end else begin
               state_next_s = IDLE;
            end
         end
         ACCUM: begin
            add_s = prod_valid;
            if (prod_valid && (count_r == LAST_CNT)) begin
               state_next_s = DONE;
               finish_s     = 1'b1;
            end else begin
               state_next_s = ACCUM;
            end
         end
         DONE: begin
            if (out_ready && start) begin
               state_next_s = ACCUM;
               load_s       = 1'b1;
            end else if (out_ready) begin
               state_next_s = IDLE;
            end else begin
               state_next_s = DONE;
            end
         end
         default: begin
            state_next_s = IDLE;
         end
      endcase
   end

   // Accumulator, term counter and registered outputs.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         acc_r     <= '0;
         count_r   <= '0;
         busy      <= 1'b0;
         out_valid <= 1'b0;
         out_data  <= '0;
         sat_flag  <= 1'b0;
      end else begin
         busy <= (state_next_s != IDLE);
         if (load_s) begin
            acc_r   <= bias_ext_s;
            count_r <= '0;
         end else if (add_s) begin
            acc_r   <= acc_sum_s;
            count_r <= count_r + CNT_W'(1);
         end
         if (finish_s) begin
            out_valid <= 1'b1;
            out_data  <= sat_value_s;
            sat_flag  <= sat_clip_s;
         end else if ((state_r == DONE) && out_ready) begin
            out_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_sneuron_accum.sv
// Self-checking bench for sneuron_accum: directed table, random vectors against
// an arithmetic reference model, and hand-written multi-cycle sequences.
module tb_sneuron_accum;

   logic              clk = 1'b0;
   logic              n_rst = 1'b0;
   logic              start = 1'b0;
   logic [13:0]       bias = '0;
   logic              prod_valid = 1'b0;
   logic [16:0]       prod_in = '0;
   logic              busy;
   logic              out_valid;
   logic              out_ready = 1'b0;
   logic [13:0]       out_data;
   logic              sat_flag;

   int n_checks = 0;
   int n_fail   = 0;

   sneuron_accum dut (
      .clk(clk), .n_rst(n_rst), .start(start), .bias(bias),
      .prod_valid(prod_valid), .prod_in(prod_in), .busy(busy),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .sat_flag(sat_flag)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic signed [13:0] bias;
      logic [7:0][16:0]   prods;
      int                 gap_lo;
      int                 gap_hi;
      int                 exp_data;
      int                 exp_sat;
   } vec_t;

   task automatic check(input string name, input int got, input int exp);
      n_checks++;
      if (got != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [7:0][16:0] fill(input int v);
      logic [7:0][16:0] p;
      for (int i = 0; i < 8; i++) p[i] = 17'(v);
      return p;
   endfunction

   // Reference: exact integer sum, floor-divide by 16, clip, optional ReLU.
   function automatic void ref_eval(input int b, input logic [7:0][16:0] p,
                                    output int data, output int sat);
      longint s;
      longint q;
      s = b;
      for (int i = 0; i < 8; i++) s += longint'($signed(p[i]));
      q = (s >= 0) ? s / 16 : -((-s + 15) / 16);
      sat = 0;
      if (q > 8191) begin q = 8191; sat = 1; end
      else if (q < -8192) begin q = -8192; sat = 1; end
`ifdef SNEURON_RELU_EN
      if (q < 0) begin q = 0; sat = 0; end
`endif
      data = int'(q);
   endfunction

   // One full evaluation; checks latency and returns the result, then handshakes.
   task automatic run_eval(input logic signed [13:0] b, input logic [7:0][16:0] p,
                           input int gap_lo, input int gap_hi,
                           output int data, output int sat);
      int early;
      early = 0;
      start = 1'b1;
      bias  = b;
      tick();
      start = 1'b0;
      for (int i = 0; i < 8; i++) begin
         if (i > 0) begin
            int g;
            g = int'($urandom_range(gap_hi, gap_lo));
            for (int k = 0; k < g; k++) begin
               tick();
               if (out_valid) early = 1;
            end
         end
         prod_valid = 1'b1;
         prod_in    = p[i];
         tick();
         prod_valid = 1'b0;
         if (i < 7 && out_valid) early = 1;
      end
      check("no_early_valid", early, 0);
      check("valid_latency", int'(out_valid), 1);
      data = int'($signed(out_data));
      sat  = int'(sat_flag);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      check("valid_cleared", int'(out_valid), 0);
   endtask

   vec_t vecs[5];
   int   d, s, ed, es;

   initial begin
      vecs[0] = '{bias: 14'sd0, prods: fill(100), gap_lo: 0, gap_hi: 0, exp_data: 50, exp_sat: 0};
      vecs[1].bias = -14'sd20;
      vecs[1].prods[0] = 17'd1000;
      for (int i = 1; i < 4; i++) vecs[1].prods[i] = 17'(-200);
      for (int i = 4; i < 8; i++) vecs[1].prods[i] = 17'd500;
      vecs[1].gap_lo = 1; vecs[1].gap_hi = 3; vecs[1].exp_data = 148; vecs[1].exp_sat = 0;
      vecs[2] = '{bias: 14'sd0, prods: fill(65535), gap_lo: 0, gap_hi: 1, exp_data: 8191, exp_sat: 1};
`ifdef SNEURON_RELU_EN
      vecs[3] = '{bias: 14'sd0, prods: fill(-65536), gap_lo: 0, gap_hi: 0, exp_data: 0, exp_sat: 0};
      vecs[4] = '{bias: -14'sd100, prods: fill(-3), gap_lo: 0, gap_hi: 2, exp_data: 0, exp_sat: 0};
`else
      vecs[3] = '{bias: 14'sd0, prods: fill(-65536), gap_lo: 0, gap_hi: 0, exp_data: -8192, exp_sat: 1};
      vecs[4] = '{bias: -14'sd100, prods: fill(-3), gap_lo: 0, gap_hi: 2, exp_data: -8, exp_sat: 0};
`endif

      // Reset state.
      #12;
      check("rst_busy", int'(busy), 0);
      check("rst_valid", int'(out_valid), 0);
      check("rst_data", int'(out_data), 0);
      check("rst_sat", int'(sat_flag), 0);
      n_rst = 1'b1;
      tick();

      // Products outside an evaluation are ignored.
      prod_valid = 1'b1; prod_in = 17'd4000;
      tick();
      prod_valid = 1'b0;
      check("idle_ignores_prod", int'(busy), 0);

      for (int v = 0; v < 5; v++) begin
         run_eval(vecs[v].bias, vecs[v].prods, vecs[v].gap_lo, vecs[v].gap_hi, d, s);
         check($sformatf("vec%0d_data", v), d, vecs[v].exp_data);
         check($sformatf("vec%0d_sat", v), s, vecs[v].exp_sat);
         tick();
      end

      // Random vectors against the reference model.
      for (int r = 0; r < 40; r++) begin
         logic [7:0][16:0]   p;
         logic signed [13:0] b;
         b = 14'(int'($urandom_range(16383, 0)) - 8192);
         for (int i = 0; i < 8; i++) begin
            if (r % 2 == 0) p[i] = 17'(int'($urandom_range(131071, 0)) - 65536);
            else            p[i] = 17'(int'($urandom_range(8191, 0)) - 4096);
         end
         ref_eval(int'(b), p, ed, es);
         run_eval(b, p, 0, 2, d, s);
         check($sformatf("rand%0d_data", r), d, ed);
         check($sformatf("rand%0d_sat", r), s, es);
      end

      // Backpressure, stray product in DONE, then back-to-back start.
      start = 1'b1; bias = '0;
      tick();
      start = 1'b0;
      for (int i = 0; i < 8; i++) begin
         prod_valid = 1'b1; prod_in = 17'd100;
         tick();
      end
      prod_valid = 1'b0;
      for (int k = 0; k < 5; k++) begin
         prod_valid = (k == 2);
         prod_in    = 17'd3000;
         start      = (k == 3);
         tick();
         check("bp_valid_held", int'(out_valid), 1);
         check("bp_data_held", int'($signed(out_data)), 50);
      end
      prod_valid = 1'b0;
      start = 1'b1; bias = 14'sd7; out_ready = 1'b1;
      tick();
      start = 1'b0; out_ready = 1'b0;
      check("b2b_valid_low", int'(out_valid), 0);
      check("b2b_busy", int'(busy), 1);
      check("b2b_data_kept", int'($signed(out_data)), 50);
      for (int i = 0; i < 8; i++) begin
         check("b2b_not_early", int'(out_valid), 0);
         prod_valid = 1'b1; prod_in = 17'd32;
         tick();
      end
      prod_valid = 1'b0;
      check("b2b_valid", int'(out_valid), 1);
      check("b2b_data", int'($signed(out_data)), 16);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      check("b2b_to_idle", int'(busy), 0);

      // Reset mid-accumulation discards the partial sum.
      start = 1'b1; bias = 14'sd500;
      tick();
      start = 1'b0;
      for (int i = 0; i < 3; i++) begin
         prod_valid = 1'b1; prod_in = 17'd9000;
         tick();
      end
      prod_valid = 1'b0;
      n_rst = 1'b0;
      #2;
      check("mid_rst_busy", int'(busy), 0);
      check("mid_rst_valid", int'(out_valid), 0);
      check("mid_rst_data", int'(out_data), 0);
      tick();
      n_rst = 1'b1;
      tick();
      run_eval(14'sd0, fill(16), 0, 0, d, s);
      check("post_rst_data", d, 8);
      check("post_rst_sat", s, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
